// File: rtl/store_buffer_pkg.sv
// Store buffer shared definitions: entry field widths and entry layout.
// Forwarding is enabled by defining STORE_BUF_FWD_EN (undefined by default).
package store_buffer_pkg;

  localparam int SB_ADDR_W = 30;
  localparam int SB_DATA_W = 32;
  localparam int SB_MASK_W = 4;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [SB_MASK_W-1:0] mask;
  } sb_entry_t;

  localparam int SB_ENT_W = $bits(sb_entry_t);

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-lane youngest-match merge of buffered store bytes for load forwarding.
// Built only when STORE_BUF_FWD_EN is defined.
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH*SB_ENT_W-1:0] ents,
  input  logic [DEPTH-1:0]          valid,
  input  logic [PW-1:0]             head,
  input  logic [SB_ADDR_W-1:0]      ld_word,
  output logic [SB_DATA_W-1:0]      data,
  output logic [SB_MASK_W-1:0]      mask
);

  sb_entry_t ent [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign ent[i] = ents[i*SB_ENT_W +: SB_ENT_W];
  end

  logic [PW-1:0] idx;

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    data = '0;
    mask = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && ent[idx].addr == ld_word) begin
        for (int b = 0; b < SB_MASK_W; b++) begin
          if (ent[idx].mask[b]) begin
            data[8*b +: 8] = ent[idx].data[8*b +: 8];
            mask[b]        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between partial-store stage and memory write port.
// Define STORE_BUF_FWD_EN to build store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  input  logic [31:0]          st_addr,
  input  logic [31:0]          st_data,
  input  logic [3:0]           st_mask,
  output logic                 st_ready,
  output logic                 mem_wvalid,
  output logic [29:0]          mem_waddr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wmask,
  input  logic                 mem_wready,
  input  logic [31:0]          ld_addr,
  output logic [31:0]          ld_fwd_data,
  output logic [3:0]           ld_fwd_mask,
  output logic [CW-1:0]        count,
  output logic                 empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t     ent_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  assign st_ready   = (count_q != CW'(DEPTH));
  assign mem_wvalid = (count_q != '0);
  assign empty      = (count_q == '0);
  assign count      = count_q;

  assign push = st_valid && st_ready && (st_mask != '0);
  assign pop  = mem_wvalid && mem_wready;

  assign mem_waddr = ent_q[head_q].addr;
  assign mem_wdata = ent_q[head_q].data;
  assign mem_wmask = ent_q[head_q].mask;

  // Entries are cleared too so the head outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (push) begin
        ent_q[tail_q] <= '{addr: st_addr[31:2], data: st_data, mask: st_mask};
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      if (push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH*SB_ENT_W-1:0] ents_flat;
  logic [DEPTH-1:0]          ent_valid;
  logic [PW-1:0]             off;
  logic [1:0]                unused_ld_lo;

  assign unused_ld_lo = ld_addr[1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign ents_flat[i*SB_ENT_W +: SB_ENT_W] = ent_q[i];
  end

  // Slot i is occupied when its distance from head is below count.
  always_comb begin
    ent_valid = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - head_q;
      ent_valid[i] = (CW'(off) < count_q);
    end
  end

  sb_fwd_merge #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .ents    (ents_flat),
    .valid   (ent_valid),
    .head    (head_q),
    .ld_word (ld_addr[31:2]),
    .data    (ld_fwd_data),
    .mask    (ld_fwd_mask)
  );
`else
  logic [31:0] unused_ld;

  assign unused_ld   = ld_addr;
  assign ld_fwd_data = '0;
  assign ld_fwd_mask = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table plus queue scoreboard.
// Forwarding expectations follow STORE_BUF_FWD_EN.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        wr;
    logic [31:0] ld;
    logic [31:0] fd;
    logic [3:0]  fm;
  } vec_t;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_mask;
  logic          st_ready;
  logic          mem_wvalid;
  logic [29:0]   mem_waddr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_wready;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_fwd_data;
  logic [3:0]    ld_fwd_mask;
  logic [CW-1:0] count;
  logic          empty;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  wr_t  sb[$];

  localparam logic [31:0] NA = 32'hFFFF_FFF0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_mask     (st_mask),
    .st_ready    (st_ready),
    .mem_wvalid  (mem_wvalid),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_wready  (mem_wready),
    .ld_addr     (ld_addr),
    .ld_fwd_data (ld_fwd_data),
    .ld_fwd_mask (ld_fwd_mask),
    .count       (count),
    .empty       (empty)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t vv(input logic v, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m,
                              input logic wr, input logic [31:0] ld,
                              input logic [31:0] fd, input logic [3:0] fm);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.m = m; r.wr = wr; r.ld = ld;
    r.fd = FWD ? fd : 32'h0;
    r.fm = FWD ? fm : 4'h0;
    return r;
  endfunction

  // Check state before the edge, then advance the scoreboard.
  task automatic tick(input vec_t t, input int n);
    logic do_pop;
    logic do_push;
    wr_t  w;
    st_valid   = t.v;
    st_addr    = t.a;
    st_data    = t.d;
    st_mask    = t.m;
    mem_wready = t.wr;
    ld_addr    = t.ld;
    #1;
    chk($sformatf("v%0d count", n), 32'(count), 32'(sb.size()));
    chk($sformatf("v%0d empty", n), 32'(empty), 32'(sb.size() == 0));
    chk($sformatf("v%0d st_ready", n), 32'(st_ready),
        32'(sb.size() != DEPTH));
    chk($sformatf("v%0d mem_wvalid", n), 32'(mem_wvalid),
        32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk($sformatf("v%0d mem_waddr", n), 32'(mem_waddr), 32'(sb[0].a));
      chk($sformatf("v%0d mem_wdata", n), mem_wdata, sb[0].d);
      chk($sformatf("v%0d mem_wmask", n), 32'(mem_wmask), 32'(sb[0].m));
    end
    chk($sformatf("v%0d fwd_data", n), ld_fwd_data, t.fd);
    chk($sformatf("v%0d fwd_mask", n), 32'(ld_fwd_mask), 32'(t.fm));
    do_pop  = (sb.size() != 0) && t.wr;
    do_push = t.v && (sb.size() != DEPTH) && (t.m != 4'h0);
    if (do_pop) void'(sb.pop_front());
    if (do_push) begin
      w.a = t.a[31:2]; w.d = t.d; w.m = t.m;
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    mem_wready = 1'b0; ld_addr = NA;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst count", 32'(count), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst st_ready", 32'(st_ready), 1);
    chk("rst mem_wvalid", 32'(mem_wvalid), 0);
    chk("rst mem_waddr", 32'(mem_waddr), 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wmask", 32'(mem_wmask), 0);
    chk("rst fwd_data", ld_fwd_data, 0);
    chk("rst fwd_mask", 32'(ld_fwd_mask), 0);

    vecs.push_back(vv(1, 32'h100, 32'h0000_00AB, 4'b0001, 0, NA, 0, 0));
    vecs.push_back(vv(0, 0, 0, 0, 0, NA, 0, 0));
    vecs.push_back(vv(0, 0, 0, 0, 0, NA, 0, 0));
    vecs.push_back(vv(0, 0, 0, 0, 1, NA, 0, 0));
    vecs.push_back(vv(0, 0, 0, 0, 0, NA, 0, 0));
    vecs.push_back(vv(1, 32'h300, 32'hDEAD_BEEF, 4'b0000, 0, NA, 0, 0));
    vecs.push_back(vv(0, 0, 0, 0, 0, NA, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(vv(1, 32'h400 + 32'(4*i), 32'hC0DE_0000 + 32'(i),
                        4'hF, 0, NA, 0, 0));
    for (int i = 5; i < 8; i++)
      vecs.push_back(vv(1, 32'h400 + 32'(4*i), 32'hC0DE_0000 + 32'(i),
                        4'hF, 1, NA, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(vv(0, 0, 0, 0, 1, NA, 0, 0));
    vecs.push_back(vv(0, 0, 0, 0, 0, NA, 0, 0));
    vecs.push_back(vv(1, 32'h200, 32'h1122_3344, 4'b1111, 0, NA, 0, 0));
    vecs.push_back(vv(1, 32'h202, 32'hAABB_0000, 4'b1100, 0, NA, 0, 0));
    vecs.push_back(vv(0, 0, 0, 0, 0, 32'h200, 32'hAABB_3344, 4'b1111));
    vecs.push_back(vv(0, 0, 0, 0, 0, 32'h204, 32'h0, 4'b0000));
    vecs.push_back(vv(1, 32'h200, 32'h0000_0055, 4'b0001, 1, 32'h200,
                      32'hAABB_3344, 4'b1111));
    vecs.push_back(vv(0, 0, 0, 0, 0, 32'h201, 32'hAABB_0055, 4'b1101));
    vecs.push_back(vv(0, 0, 0, 0, 1, 32'h200, 32'hAABB_0055, 4'b1101));
    vecs.push_back(vv(0, 0, 0, 0, 1, 32'h200, 32'h0000_0055, 4'b0001));
    vecs.push_back(vv(0, 0, 0, 0, 0, 32'h200, 32'h0, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) tick(vecs[i], i);

    // Reset with three entries queued and a write being presented.
    tick(vv(1, 32'h500, 32'h0102_0304, 4'hF, 0, NA, 0, 0), 100);
    tick(vv(1, 32'h504, 32'h0506_0708, 4'hF, 0, NA, 0, 0), 101);
    tick(vv(1, 32'h500, 32'h0A0B_0C0D, 4'h3, 0, 32'h500,
            32'h0102_0304, 4'hF), 102);
    st_valid = 1'b0; mem_wready = 1'b0; ld_addr = 32'h500;
    #1;
    chk("pre-rst count", 32'(count), 3);
    chk("pre-rst fwd_mask", 32'(ld_fwd_mask), FWD ? 32'hF : 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("midrst count", 32'(count), 0);
    chk("midrst mem_wvalid", 32'(mem_wvalid), 0);
    chk("midrst empty", 32'(empty), 1);
    chk("midrst fwd_mask", 32'(ld_fwd_mask), 0);
    tick(vv(0, 0, 0, 0, 1, 32'h500, 0, 0), 103);
    tick(vv(1, 32'h600, 32'h7777_8888, 4'b0110, 0, NA, 0, 0), 104);
    tick(vv(0, 0, 0, 0, 1, 32'h600, 32'h0077_8800, 4'b0110), 105);
    tick(vv(0, 0, 0, 0, 0, 32'h600, 0, 0), 106);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
